multicycle_control: RTL and testbench

Multi-cycle control unit for the RV32I subset core: lw, sw, R-type add/sub/and/or/slt, I-type ALU ops, beq/bne. A Moore/Mealy FSM sequences fetch, decode, execute, memory and writeback over the shared ALU, memory port and register file. It also drives the select that packs the 12-bit immediate field (I, S or B layout) into the sign-extending immediate generator. It adds a memory-ready handshake with a timeout watchdog and a sticky trap state.

---
 rtl/multicycle_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset control FSM: sequences fetch/decode/execute/memory/writeback,
// with a memory-ready handshake, a timeout watchdog and a sticky trap state.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AddrSrc,
  output logic       MemToReg,
  output logic       PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSel,
  output logic [3:0] State,
  output logic       IllegalOp,
  output logic       MemTimeout
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } state_t;

  localparam logic [8:0] TMO = 9'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       mem_state, expired, illegal_set, timeout_set;
  logic       is_load, is_store, is_rtype, is_itype, is_branch;

  always_comb begin
    is_load   = (Opcode == 7'b0000011) && (Funct3 == 3'b010);
    is_store  = (Opcode == 7'b0100011) && (Funct3 == 3'b010);
    is_rtype  = (Opcode == 7'b0110011);
    is_itype  = (Opcode == 7'b0010011);
    is_branch = (Opcode == 7'b1100011) && ((Funct3 == 3'b000) || (Funct3 == 3'b001));
    mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    // Timeout fires on the waiting cycle that would bring the count up to the limit;
    // a MemReady in that same cycle still completes the access.
    expired   = (TMO != 9'd0) && mem_state && !MemReady && (({1'b0, cnt} + 9'd1) == TMO);
  end

  always_comb begin
    state_nxt   = state;
    illegal_set = 1'b0;
    timeout_set = 1'b0;
    case (state)
      FETCH: begin
        if (MemReady) state_nxt = DECODE;
        else if (expired) begin
          state_nxt   = TRAP;
          timeout_set = 1'b1;
        end
      end
      DECODE: begin
        if (is_load || is_store) state_nxt = MEMADR;
        else if (is_rtype)       state_nxt = EXECR;
        else if (is_itype)       state_nxt = EXECI;
        else if (is_branch)      state_nxt = BRANCH;
        else begin
          state_nxt   = TRAP;
          illegal_set = 1'b1;
        end
      end
      MEMADR:  state_nxt = (Opcode == 7'b0100011) ? MEMWRITE : MEMREAD;
      MEMREAD, MEMWRITE: begin
        if (MemReady) state_nxt = (state == MEMREAD) ? MEMWB : FETCH;
        else if (expired) begin
          state_nxt   = TRAP;
          timeout_set = 1'b1;
        end
      end
      MEMWB:        state_nxt = FETCH;
      EXECR, EXECI: state_nxt = ALUWB;
      ALUWB:        state_nxt = FETCH;
      BRANCH:       state_nxt = FETCH;
      TRAP:         state_nxt = TRAP;
      default:      state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      cnt        <= 8'd0;
      IllegalOp  <= 1'b0;
      MemTimeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= 8'd0;
      else if (mem_state && !MemReady)
        cnt <= cnt + 8'd1;
      IllegalOp  <= IllegalOp | illegal_set;
      MemTimeout <= MemTimeout | timeout_set;
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    AddrSrc  = 1'b0;
    MemToReg = 1'b0;
    PCSrc    = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    ImmSel   = 2'b00;
    State    = state;
    // Reset suppresses every output decode so an aborted instruction issues nothing.
    if (!reset) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        DECODE: begin
          ALUSrcB = 2'b10;
          ImmSel  = 2'b10;
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ImmSel  = (Opcode == 7'b0100011) ? 2'b01 : 2'b00;
        end
        MEMREAD: begin
          MemRead = 1'b1;
          AddrSrc = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        MEMWRITE: begin
          MemWrite = 1'b1;
          AddrSrc  = 1'b1;
        end
        EXECR: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        EXECI: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b10;
        end
        ALUWB:  RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b01;
          PCSrc   = 1'b1;
          PCWrite = (Funct3 == 3'b000) ? Zero : !Zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level trace generator
// queues expected per-cycle outputs; a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam int TMO = 4;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, rw, mr, mw, as, m2r, pcs, asa;
    logic [1:0] asb, aop, imm;
    logic ill, to;
  } rec_t;

  logic clk, reset, Zero, MemReady;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AddrSrc, MemToReg, PCSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, ImmSel;
  logic [3:0] State;
  logic IllegalOp, MemTimeout;

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct3(Funct3), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .AddrSrc(AddrSrc), .MemToReg(MemToReg),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSel(ImmSel),
    .State(State), .IllegalOp(IllegalOp), .MemTimeout(MemTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rec_t  expq[$];
  rec_t  maskq[$];
  string tagq[$];
  int    checks = 0;
  int    passes = 0;
  logic  ill_flag = 1'b0;
  logic  to_flag  = 1'b0;

  rec_t act;
  always_comb begin
    act = '0;
    act.st = State;  act.pcw = PCWrite; act.irw = IRWrite; act.rw = RegWrite;
    act.mr = MemRead; act.mw = MemWrite; act.as = AddrSrc; act.m2r = MemToReg;
    act.pcs = PCSrc; act.asa = ALUSrcA; act.asb = ALUSrcB; act.aop = ALUOp;
    act.imm = ImmSel; act.ill = IllegalOp; act.to = MemTimeout;
  end

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      rec_t  e, m;
      string t;
      e = expq.pop_front();
      m = maskq.pop_front();
      t = tagq.pop_front();
      checks++;
      if ((act & m) === (e & m)) passes++;
      else $display("FAIL %s: got %h expected %h (mask %h) at %0t", t, act, e, m, $time);
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic rec_t mk(input logic [3:0] st);
    rec_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  task automatic push(input rec_t r, input rec_t m, input string tag);
    expq.push_back(r);
    maskq.push_back(m);
    tagq.push_back(tag);
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, advance.
  task automatic step(input logic rdy, input logic z, input rec_t r, input string tag);
    MemReady = rdy;
    Zero     = z;
    r.ill = ill_flag;
    r.to  = to_flag;
    push(r, '1, tag);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n, input logic rdy);
    rec_t m;
    for (int i = 0; i < n; i++) begin
      reset    = 1'b1;
      MemReady = rdy;
      Zero     = rb();
      m = '1;
      if (i == 0) begin
        m.st = '0; m.ill = 1'b0; m.to = 1'b0;   // still the pre-reset registered values
      end
      push(mk(4'd0), m, "reset");
      @(posedge clk); #1;
    end
    reset    = 1'b0;
    ill_flag = 1'b0;
    to_flag  = 1'b0;
  endtask

  task automatic trap_hold(input int n, input string tag);
    for (int i = 0; i < n; i++) step(rb(), rb(), mk(4'd10), tag);
  endtask

  // A memory access that stalls w cycles; w >= TMO means it never completes.
  task automatic mem_wait(input rec_t base, input rec_t done, input int w,
                          input string tag, output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; i < w && i < TMO; i++) step(1'b0, rb(), base, tag);
    if (w >= TMO) begin
      timed_out = 1'b1;
      to_flag   = 1'b1;
    end else step(1'b1, rb(), done, tag);
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                           input int wf, input int wm, input string tag);
    rec_t fb, fd, r;
    bit   tmo;
    bit   lw, sw, rt, it, br;
    Opcode = opc;
    Funct3 = f3;
    lw = (opc == 7'b0000011) && (f3 == 3'd2);
    sw = (opc == 7'b0100011) && (f3 == 3'd2);
    rt = (opc == 7'b0110011);
    it = (opc == 7'b0010011);
    br = (opc == 7'b1100011) && (f3 < 3'd2);

    fb = mk(4'd0); fb.mr = 1'b1; fb.asb = 2'b01;
    fd = fb; fd.irw = 1'b1; fd.pcw = 1'b1;
    mem_wait(fb, fd, wf, tag, tmo);
    if (tmo) begin
      trap_hold(3, tag);
      do_reset(2, rb());
      return;
    end

    r = mk(4'd1); r.asb = 2'b10; r.imm = 2'b10;
    step(rb(), rb(), r, tag);

    if (lw || sw) begin
      r = mk(4'd2); r.asa = 1'b1; r.asb = 2'b10; r.imm = sw ? 2'b01 : 2'b00;
      step(rb(), rb(), r, tag);
      if (sw) begin
        r = mk(4'd5); r.mw = 1'b1; r.as = 1'b1;
      end else begin
        r = mk(4'd3); r.mr = 1'b1; r.as = 1'b1;
      end
      mem_wait(r, r, wm, tag, tmo);
      if (tmo) begin
        trap_hold(3, tag);
        do_reset(2, rb());
        return;
      end
      if (lw) begin
        r = mk(4'd4); r.rw = 1'b1; r.m2r = 1'b1;
        step(rb(), rb(), r, tag);
      end
    end else if (rt || it) begin
      r = mk(rt ? 4'd6 : 4'd7); r.asa = 1'b1; r.aop = 2'b10; r.asb = rt ? 2'b00 : 2'b10;
      step(rb(), rb(), r, tag);
      r = mk(4'd8); r.rw = 1'b1;
      step(rb(), rb(), r, tag);
    end else if (br) begin
      r = mk(4'd9); r.asa = 1'b1; r.aop = 2'b01; r.pcs = 1'b1;
      r.pcw = (f3 == 3'd0) ? z : !z;
      step(rb(), z, r, tag);
    end else begin
      ill_flag = 1'b1;
      trap_hold(10, tag);
      do_reset(2, rb());
    end
  endtask

  initial begin
    reset = 1'b1; MemReady = 1'b1; Zero = 1'b0; Opcode = '0; Funct3 = '0;
    @(posedge clk); #1;
    do_reset(2, 1'b1);

    run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, "add");
    run_instr(7'b0000011, 3'd2, 1'b0, 0, 3, "lw_wait3");
    run_instr(7'b0100011, 3'd2, 1'b0, 0, 0, "sw");
    run_instr(7'b1100011, 3'd0, 1'b1, 0, 0, "beq_taken");
    run_instr(7'b1100011, 3'd1, 1'b1, 0, 0, "bne_not_taken");
    run_instr(7'b1100011, 3'd1, 1'b0, 1, 0, "bne_taken");
    run_instr(7'b1111111, 3'd0, 1'b0, 0, 0, "illegal_op");
    run_instr(7'b0000011, 3'd0, 1'b0, 0, 0, "lw_bad_f3");
    run_instr(7'b0010011, 3'd5, 1'b0, TMO, 0, "fetch_timeout");
    run_instr(7'b0010011, 3'd5, 1'b0, TMO - 1, 0, "fetch_ready_at_limit");
    run_instr(7'b0100011, 3'd2, 1'b0, 2, TMO, "sw_timeout");
    run_instr(7'b0000011, 3'd2, 1'b0, 3, TMO - 1, "lw_ready_at_limit");

    begin : mid_reset
      rec_t fb;
      fb = mk(4'd0); fb.mr = 1'b1; fb.asb = 2'b01;
      step(1'b0, 1'b0, fb, "mid_fetch");
      do_reset(2, 1'b1);
      run_instr(7'b0110011, 3'd7, 1'b0, 0, 0, "after_abort");
    end

    for (int n = 0; n < 150; n++) begin
      logic [6:0] opc;
      logic [2:0] f3;
      int k, wf, wm;
      k = $urandom_range(0, 11);
      case (k)
        0, 1:    opc = 7'b0000011;
        2, 3:    opc = 7'b0100011;
        4, 5:    opc = 7'b0110011;
        6, 7:    opc = 7'b0010011;
        8, 9:    opc = 7'b1100011;
        default: opc = 7'($urandom_range(0, 127));
      endcase
      f3 = 3'($urandom_range(0, 7));
      if ((k < 4) && ($urandom_range(0, 4) != 0)) f3 = 3'd2;
      if ((k == 8 || k == 9) && ($urandom_range(0, 4) != 0)) f3 = 3'($urandom_range(0, 1));
      wf = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, TMO - 1);
      wm = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, TMO - 1);
      run_instr(opc, f3, rb(), wf, wm, "random");
    end

    repeat (2) @(posedge clk);
    if (expq.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, need 0", expq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
